// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues start with operands and observes the held result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// with the ripple borrow carried between bits in a single flop.
// Results (difference, unsigned borrow, signed overflow) are held until
// the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk1,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 difference bits produced so far; the final bit is
  // concatenated on top when the result is committed.
  logic [WIDTH-2:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  logic             x;
  logic             y;
  logic             d;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] shift_next;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full-subtractor bit cell on the current LSBs plus the held borrow.
  always_comb begin
    x          = a_sr[0];
    y          = b_sr[0];
    d          = x ^ y ^ borrow;
    bout       = (~x & y) | (~(x ^ y) & borrow);
    last       = (state == RUN) && (cnt == LAST);
    shift_next = {d, res_sr};
  end

  // Datapath: capture operands, shift one bit per RUN cycle, commit result
  // on the last bit so outputs only change on the edge entering DONE.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        a_msb  <= bus.a[WIDTH-1];
        b_msb  <= bus.b[WIDTH-1];
        borrow <= 1'b0;
        cnt    <= '0;
      end
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= shift_next[WIDTH-1:1];
      borrow <= bout;
      if (last) begin
        diff_q     <= shift_next;
        borrow_q   <= bout;
        overflow_q <= (a_msb != b_msb) && (d != a_msb);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit and a 16-bit
// instance are driven with directed vectors and a random sweep, and
// every cycle is compared with an arithmetic reference model.
module tb_serial_subtractor;

  logic clk1 = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // 10 ns clock.
  always #5 clk1 = ~clk1;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  // Reference model state, one slot per instance (0: 8-bit, 1: 16-bit).
  bit        m_busy [2];
  int        m_age  [2];
  bit [31:0] m_diff [2];
  bit        m_bor  [2];
  bit        m_ovf  [2];
  bit [31:0] p_diff [2];
  bit        p_bor  [2];
  bit        p_ovf  [2];

  function automatic int widthOf(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic logic getBusy(input int i);
    return (i == 0) ? bus8.busy : bus16.busy;
  endfunction

  function automatic logic getDone(input int i);
    return (i == 0) ? bus8.done : bus16.done;
  endfunction

  function automatic logic [31:0] getDiff(input int i);
    return (i == 0) ? 32'(bus8.diff) : 32'(bus16.diff);
  endfunction

  function automatic logic getBor(input int i);
    return (i == 0) ? bus8.borrow_out : bus16.borrow_out;
  endfunction

  function automatic logic getOvf(input int i);
    return (i == 0) ? bus8.overflow : bus16.overflow;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Arithmetic view of one clock edge: an accepted operation finishes
  // WIDTH edges later with (a-b) mod 2^W, unsigned a<b, and a signed
  // result outside the representable range; one edge after that the
  // block is idle again.
  task automatic modelStep(input int i, input logic st, input bit [31:0] av,
                           input bit [31:0] bv);
    int     w;
    longint full, half, ua, ub, sa, sb, r;
    w    = widthOf(i);
    full = longint'(1) << w;
    half = full / 2;
    if (m_busy[i]) begin
      m_age[i]++;
      if (m_age[i] == w) begin
        m_diff[i] = p_diff[i];
        m_bor[i]  = p_bor[i];
        m_ovf[i]  = p_ovf[i];
      end else if (m_age[i] == w + 1) begin
        m_busy[i] = 1'b0;
      end
    end else if (st === 1'b1) begin
      ua        = longint'(av) & (full - 1);
      ub        = longint'(bv) & (full - 1);
      sa        = (ua >= half) ? ua - full : ua;
      sb        = (ub >= half) ? ub - full : ub;
      r         = sa - sb;
      p_diff[i] = 32'((ua - ub + full) % full);
      p_bor[i]  = (ua < ub);
      p_ovf[i]  = (r < -half) || (r >= half);
      m_busy[i] = 1'b1;
      m_age[i]  = 0;
    end
  endtask

  // Advance the model on every edge; reset clears it immediately.
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_age[i]  = 0;
        m_diff[i] = '0;
        m_bor[i]  = 1'b0;
        m_ovf[i]  = 1'b0;
      end
    end else begin
      modelStep(0, bus8.start, 32'(bus8.a), 32'(bus8.b));
      modelStep(1, bus16.start, 32'(bus16.a), 32'(bus16.b));
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk1) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("busy%0d", widthOf(i)), 32'(getBusy(i)), 32'(m_busy[i]));
        checkOutput($sformatf("done%0d", widthOf(i)), 32'(getDone(i)),
                    32'(m_busy[i] && (m_age[i] == widthOf(i))));
        checkOutput($sformatf("diff%0d", widthOf(i)), getDiff(i), m_diff[i]);
        checkOutput($sformatf("borrow%0d", widthOf(i)), 32'(getBor(i)), 32'(m_bor[i]));
        checkOutput($sformatf("overflow%0d", widthOf(i)), 32'(getOvf(i)), 32'(m_ovf[i]));
      end
    end
  end

  task automatic setInputs(input int i, input logic st, input logic [31:0] av,
                           input logic [31:0] bv);
    if (i == 0) begin
      bus8.start = st;
      bus8.a     = av[7:0];
      bus8.b     = bv[7:0];
    end else begin
      bus16.start = st;
      bus16.a     = av[15:0];
      bus16.b     = bv[15:0];
    end
  endtask

  // One start pulse, then wait (bounded) for done; latency is counted in
  // negedges after the driving one, so done after WIDTH edges gives W+1.
  task automatic applyStimulus(input int i, input logic [31:0] av,
                               input logic [31:0] bv);
    int n;
    @(negedge clk1);
    setInputs(i, 1'b1, av, bv);
    n = 0;
    do begin
      @(negedge clk1);
      n++;
      if (n == 1) setInputs(i, 1'b0, 32'h0, 32'h0);
    end while (getDone(i) !== 1'b1 && n < 4 * widthOf(i));
    checkOutput($sformatf("latency%0d", widthOf(i)), 32'(n), 32'(widthOf(i) + 1));
  endtask

  task automatic runDirected(input string name, input int i, input logic [31:0] av,
                             input logic [31:0] bv, input logic [31:0] expDiff,
                             input logic expBor, input logic expOvf);
    applyStimulus(i, av, bv);
    checkOutput({name, "_diff"}, getDiff(i), expDiff);
    checkOutput({name, "_borrow"}, 32'(getBor(i)), 32'(expBor));
    checkOutput({name, "_overflow"}, 32'(getOvf(i)), 32'(expOvf));
  endtask

  // Directed scenarios followed by the 16-bit random sweep.
  initial begin
    int doneCount;
    int firstDone;
    int secondDone;

    rst_n = 1'b0;
    setInputs(0, 1'b0, 32'h0, 32'h0);
    setInputs(1, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk1);

    checkOutput("reset_busy", 32'(bus8.busy), 32'h0);
    checkOutput("reset_done", 32'(bus8.done), 32'h0);
    checkOutput("reset_diff", 32'(bus8.diff), 32'h0);
    rst_n = 1'b1;

    runDirected("sub_5a_23", 0, 32'h5A, 32'h23, 32'h37, 1'b0, 1'b0);
    runDirected("sub_23_5a", 0, 32'h23, 32'h5A, 32'hC9, 1'b1, 1'b0);
    runDirected("sub_80_01", 0, 32'h80, 32'h01, 32'h7F, 1'b0, 1'b1);
    runDirected("sub_7f_ff", 0, 32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1);

    // Reset in the middle of an operation clears everything at once.
    @(negedge clk1);
    setInputs(0, 1'b1, 32'hFF, 32'h01);
    @(negedge clk1);
    setInputs(0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus8.busy), 32'h0);
    checkOutput("midrst_done", 32'(bus8.done), 32'h0);
    checkOutput("midrst_diff", 32'(bus8.diff), 32'h0);
    checkOutput("midrst_borrow", 32'(bus8.borrow_out), 32'h0);
    checkOutput("midrst_overflow", 32'(bus8.overflow), 32'h0);
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (12) begin
      @(negedge clk1);
      if (bus8.done === 1'b1) doneCount++;
    end
    checkOutput("midrst_no_done", 32'(doneCount), 32'h0);
    runDirected("sub_10_01", 0, 32'h10, 32'h01, 32'h0F, 1'b0, 1'b0);

    // Start held high: re-accepted every WIDTH+2 cycles. Operands and
    // start wiggled while busy must not disturb the operation in flight.
    @(negedge clk1);
    setInputs(0, 1'b1, 32'h00, 32'h00);
    doneCount  = 0;
    firstDone  = 0;
    secondDone = 0;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk1);
      if (n == 2) setInputs(0, 1'b1, 32'hAB, 32'h12);
      if (n == 9) setInputs(0, 1'b1, 32'h00, 32'h00);
      if (n == 11) setInputs(0, 1'b0, 32'h00, 32'h00);
      if (bus8.done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin
          firstDone = n;
          checkOutput("b2b_diff", 32'(bus8.diff), 32'h00);
          checkOutput("b2b_borrow", 32'(bus8.borrow_out), 32'h0);
          checkOutput("b2b_overflow", 32'(bus8.overflow), 32'h0);
        end else begin
          secondDone = n;
        end
      end
    end
    checkOutput("b2b_done_count", 32'(doneCount), 32'h2);
    checkOutput("b2b_first_done", 32'(firstDone), 32'h9);
    checkOutput("b2b_spacing", 32'(secondDone - firstDone), 32'hA);

    runDirected("sub16_8000_0001", 1, 32'h8000, 32'h0001, 32'h7FFF, 1'b0, 1'b1);
    runDirected("sub16_0000_ffff", 1, 32'h0000, 32'hFFFF, 32'h0001, 1'b1, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1, $urandom & 32'hFFFF, $urandom & 32'hFFFF);
    end

    repeat (3) @(negedge clk1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `A - B` one bit per clock, LSB first, with a ripple borrow held in a flip-flop. It is the inverse-operation counterpart to the team's combinational half-adder cell, built from the matching half-subtractor/full-subtractor bit cell. Operands are accepted through a start/busy/done handshake, and the result is held until the next operation completes. It sits in the `adder/` arithmetic library as the small-area subtract path.

## Interface

- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk1`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a subtraction; sampled only in IDLE.
- `a`  in  WIDTH: minuend; captured on the accepting edge.
- `b`  in  WIDTH: subtrahend; captured on the accepting edge.
- `busy`  out  1: high in RUN and DONE; the block is not accepting `start`.
- `done`  out  1: one-cycle pulse; the result outputs are valid and newly updated.
- `diff`  out  WIDTH: `(a - b) mod 2^WIDTH`, registered and held.
- `borrow_out`  out  1: unsigned underflow, i.e. `a < b` unsigned; registered and held.
- `overflow`  out  1: signed two's-complement overflow of `a - b`; registered and held.

## Operation

- States:
  - IDLE: waits for `start`.
  - RUN: processes WIDTH bits.
  - DONE: one cycle, signals completion.
- IDLE, `start`=1: capture `a` and `b` into shift registers, clear the borrow flop, clear the bit counter, go to RUN. Otherwise stay in IDLE.
- RUN, each cycle, with `x` = LSB of the A shift register, `y` = LSB of the B shift register, `bin` = borrow flop:
  - `d = x ^ y ^ bin`
  - `bout = (~x & y) | (~(x ^ y) & bin)`
  - Shift `d` into the MSB of the result shift register (right shift).
  - Shift A and B right by one.
  - Borrow flop takes `bout`. Counter increments.
- RUN, when the counter equals WIDTH-1 (last bit):
  - `diff` is loaded with the completed shift value, with the final `d` placed at the MSB.
  - `borrow_out` takes the final `bout`.
  - `overflow` is `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the captured operands.
  - Next state is DONE.
- DONE: `done`=1 for exactly this cycle; next state is IDLE.
- `start` in RUN or DONE is ignored; the operands are not re-captured and there is no queuing.
- `diff`, `borrow_out` and `overflow` change only on the edge that enters DONE. Between operations they hold the previous result.
- Reset:
  - `rst_n`=0 at any time forces IDLE and clears every register immediately, independent of `clk1`.
  - An operation interrupted by reset is discarded; no `done` is issued.
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `overflow`=0.

## Timing

- Let `start` be sampled high in IDLE at edge k.
  - Edges k+1 .. k+WIDTH process bits 0 .. WIDTH-1.
  - The result registers update, and `done` rises, at edge k+WIDTH.
  - `done` falls and `busy` falls at edge k+WIDTH+1.
- Latency from the accepting edge to `done`: WIDTH cycles.
- Minimum `start`-to-`start` spacing: WIDTH+2 cycles. A `start` held high continuously is re-accepted at edge k+WIDTH+2.
- `busy` rises at edge k and is combinationally equal to `state != IDLE`.
- `a` and `b` may change freely after edge k.
- The bit counter is `$clog2(WIDTH)` bits wide. It never wraps inside an operation because the exit occurs at WIDTH-1.
- `rst_n` deassertion is not required to be synchronized in this block; it is synchronized at system level.

## Test plan

1. WIDTH=8, a=0x5A, b=0x23 -> after 8 cycles `done` pulses once; diff=0x37, borrow_out=0, overflow=0.
2. a=0x23, b=0x5A -> diff=0xC9, borrow_out=1, overflow=0.
3. a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
4. Back-to-back with `start` held high and a=0x00, b=0x00 -> diff=0x00, all flags 0. `done` pulses every 10 cycles. Changing a/b and pulsing `start` while `busy` does not alter the result of the operation in flight.
5. Start a=0xFF, b=0x01; assert `rst_n`=0 at bit 4 -> all outputs 0 immediately, no `done`. After release, a fresh operation a=0x10, b=0x01 gives diff=0x0F.
6. WIDTH=16 random sweep, 1000 operations -> diff, borrow_out and overflow match a reference model. Latency is exactly 16 cycles every time.
